// File: rtl/alu_package.sv
// Shared ALU types plus the arbiter FSM state encoding.
package alu_package;

  localparam int INSTR_WIDTH = 4;

  typedef enum logic [INSTR_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3
  } alu_e;

  // c: carry/borrow out of bit N-1, v: signed overflow, n: bit N-1, z: low N bits zero
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: N+1 bit result, carry/borrow in bit N for ADD/SUB.
module alu import alu_package::*; #(
  parameter int N = 16
) (
  input  logic signed [N-1:0]           a,
  input  logic signed [N-1:0]           b,
  input  logic        [INSTR_WIDTH-1:0] op,
  output logic signed [N:0]             z,
  output alu_flags                      flags,
  output logic                          err
);

  logic [N:0] ua, ub;
  assign ua = {1'b0, a};
  assign ub = {1'b0, b};

  // Operate on zero-extended operands so bit N is the unsigned carry/borrow
  always_comb begin
    z     = '0;
    flags = '0;
    err   = 1'b0;
    case (op)
      ALU_ADD: begin
        z       = $signed(ua + ub);
        flags.c = z[N];
        flags.v = (a[N-1] == b[N-1]) && (z[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        z       = $signed(ua - ub);
        flags.c = z[N];
        flags.v = (a[N-1] != b[N-1]) && (z[N-1] != a[N-1]);
      end
      ALU_AND: z = $signed({1'b0, a & b});
      ALU_OR:  z = $signed({1'b0, a | b});
      default: err = 1'b1;
    endcase
    // Illegal opcodes leave result and flags all zero
    if (!err) begin
      flags.z = (z[N-1:0] == '0);
      flags.n = z[N-1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, one op in flight.
module alu_arbiter import alu_package::*; #(
  parameter int N       = 16,
  parameter int NUM_REQ = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ-1:0][N-1:0]                     req_a,
  input  logic [NUM_REQ-1:0][N-1:0]                     req_b,
  input  logic [NUM_REQ-1:0][INSTR_WIDTH-1:0]           req_op,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                    rsp_id,
  output logic signed [N:0]                             rsp_z,
  output alu_flags                                      rsp_flags,
  output logic                                          rsp_err
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDW-1:0]         rr_ptr, grant, cand, id_q;
  logic                   found, take;
  int                     idx;
  logic signed [N-1:0]    a_q, b_q;
  logic [INSTR_WIDTH-1:0] op_q;
  logic signed [N:0]      alu_z;
  alu_flags               alu_fl;
  logic                   alu_err;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign take = (state_q == IDLE) && found;

  // Grant strobe only in IDLE; forced low while reset is held
  always_comb begin
    req_ready = '0;
    if (rst_n && take) req_ready[grant] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found)     state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Capture granted request and advance the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      a_q    <= $signed(req_a[grant]);
      b_q    <= $signed(req_b[grant]);
      op_q   <= req_op[grant];
      id_q   <= grant;
      rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  alu #(.N(N)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .z     (alu_z),
    .flags (alu_fl),
    .err   (alu_err)
  );

  // Response registers load once in EXEC and hold through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_z     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
    end else if (state_q == EXEC) begin
      rsp_z     <= alu_z;
      rsp_flags <= alu_fl;
      rsp_err   <= alu_err;
      rsp_id    <= id_q;
    end
  end

  assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then randomized traffic vs. a transaction model.
module tb_alu_arbiter;
  import alu_package::*;

  localparam int N  = 16;
  localparam int NR = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NR-1:0]                req_valid, req_ready;
  logic [NR-1:0][N-1:0]         req_a, req_b;
  logic [NR-1:0][INSTR_WIDTH-1:0] req_op;
  logic                         rsp_valid, rsp_ready;
  logic [0:0]                   rsp_id;
  logic [N:0]                   rsp_z;
  alu_flags                     rsp_flags;
  logic                         rsp_err;

  int tests  = 0;
  int failed = 0;

  // Transaction-level model state
  bit         m_busy;
  int         m_rr;
  int         m_age;
  int         m_id;
  logic [N:0] m_z;
  alu_flags   m_f;
  bit         m_err;

  alu_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic void ref_alu(input logic [3:0] op, input logic [N-1:0] a, b,
                                  output logic [N:0] z, output alu_flags f, output bit err);
    longint ua, ub, sa, sb, r, s;
    bit arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = 0; s = 0; z = '0; f = '0; err = 0;
    arith = (op == ALU_ADD) || (op == ALU_SUB);
    if (op == ALU_ADD)      begin r = ua + ub; s = sa + sb; end
    else if (op == ALU_SUB) begin r = ua - ub + (longint'(1) << (N + 1)); s = sa - sb; end
    else if (op == ALU_AND) r = ua & ub;
    else if (op == ALU_OR)  r = ua | ub;
    else err = 1;
    if (!err) begin
      z   = r[N:0];
      f.z = (r[N-1:0] == 0);
      f.n = r[N-1];
      f.c = arith && r[N];
      f.v = arith && ((s > (longint'(1) << (N - 1)) - 1) || (s < -(longint'(1) << (N - 1))));
    end
  endfunction

  // One cycle: drive after negedge, check before posedge, then advance the model
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0][N-1:0] a, b,
                      input logic [NR-1:0][3:0] op, input bit rr_in, output int g);
    logic [NR-1:0] exp_ready;
    bit exp_valid;
    bit hit;
    int k;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = rr_in;
    #1;
    g = -1; exp_ready = '0; exp_valid = 0; hit = 0;
    if (m_busy) begin
      m_age++;
      exp_valid = (m_age >= 2);
    end else begin
      for (int j = 0; j < NR; j++) begin
        k = (m_rr + j) % NR;
        if (!hit && v[k]) begin hit = 1; g = k; end
      end
      if (hit) begin
        exp_ready[g] = 1'b1;
        ref_alu(op[g], a[g], b[g], m_z, m_f, m_err);
        m_id = g; m_age = 0; m_busy = 1;
        m_rr = (g + 1) % NR;
      end
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_z",     32'(rsp_z),     32'(m_z));
      chk("rsp_flags", 32'(rsp_flags), 32'(m_f));
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
      chk("rsp_id",    32'(rsp_id),    32'(m_id));
      if (rr_in) m_busy = 0;
    end
  endtask

  // Reset pulse with requests pending to confirm req_ready stays low
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '1;
    #1;
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_valid",  32'(rsp_valid), 32'd0);
    chk("rst_z",      32'(rsp_z),     32'd0);
    chk("rst_flags",  32'(rsp_flags), 32'd0);
    chk("rst_err",    32'(rsp_err),   32'd0);
    chk("rst_id",     32'(rsp_id),    32'd0);
    m_busy = 0; m_rr = 0;
    @(negedge clk);
    req_valid = '0; rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [NR-1:0][N-1:0] da, db;
    logic [NR-1:0][3:0]   dop;
    int g;
    int gc[$];
    int gi[$];

    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    m_busy = 0; m_rr = 0; m_age = 0; m_id = 0; m_z = '0; m_f = '0; m_err = 0;
    da = '0; db = '0; dop = '0;
    do_reset();

    // Single ADD from requester 0
    da[0] = 16'd5; db[0] = 16'd3; dop[0] = ALU_ADD;
    step(2'b01, da, db, dop, 1'b1, g);
    chk("add_grant", 32'(g), 32'd0);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);
    chk("add_z",  32'(rsp_z),       32'd8);
    chk("add_id", 32'(rsp_id),      32'd0);
    chk("add_fz", 32'(rsp_flags.z), 32'd0);
    chk("add_fn", 32'(rsp_flags.n), 32'd0);

    // Both requesters held: alternating grants three cycles apart
    do_reset();
    da[0] = 16'd1; db[0] = 16'd2; dop[0] = ALU_ADD;
    da[1] = 16'd7; db[1] = 16'd4; dop[1] = ALU_SUB;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(2'b11, da, db, dop, 1'b1, g);
      if (g >= 0) begin gc.push_back(cyc); gi.push_back(g); end
    end
    chk("rr_count", 32'(gc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gc.size()) begin
        chk("rr_cycle", 32'(gc[k]), 32'(3 * k));
        chk("rr_id",    32'(gi[k]), 32'(k % 2));
      end
    end

    // SUB zero and SUB negative from requester 1
    da[1] = 16'd3; db[1] = 16'd3; dop[1] = ALU_SUB;
    step(2'b10, da, db, dop, 1'b1, g);
    chk("sub0_grant", 32'(g), 32'd1);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);
    chk("sub0_z",  32'(rsp_z[N-1:0]), 32'd0);
    chk("sub0_fz", 32'(rsp_flags.z),  32'd1);
    chk("sub0_id", 32'(rsp_id),       32'd1);
    da[1] = 16'd2; db[1] = 16'd5;
    step(2'b10, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);
    chk("subn_z",  32'(rsp_z[N-1:0]), 32'h0000FFFD);
    chk("subn_fn", 32'(rsp_flags.n),  32'd1);

    // Back-pressure: five stalled RESP cycles, then handshake, grant next cycle
    da[0] = 16'd100; db[0] = 16'd23; dop[0] = ALU_ADD;
    step(2'b11, da, db, dop, 1'b0, g);
    chk("bp_grant", 32'(g), 32'd0);
    step(2'b11, da, db, dop, 1'b0, g);
    for (int k = 0; k < 5; k++) begin
      step(2'b11, da, db, dop, 1'b0, g);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    step(2'b11, da, db, dop, 1'b1, g);
    chk("bp_no_grant_on_hs", 32'(g), 32'hFFFFFFFF);
    step(2'b11, da, db, dop, 1'b1, g);
    chk("bp_next_grant", 32'(g), 32'd1);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);

    // Reset while EXEC discards the operation; pointer returns to 0
    step(2'b01, da, db, dop, 1'b1, g);
    do_reset();
    for (int k = 0; k < 3; k++) step(2'b00, da, db, dop, 1'b1, g);
    step(2'b11, da, db, dop, 1'b1, g);
    chk("post_rst_grant", 32'(g), 32'd0);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);

    // Illegal opcode takes a normal slot with err set and zero result
    dop[0] = 4'hF; da[0] = 16'h1234; db[0] = 16'h4321;
    step(2'b01, da, db, dop, 1'b1, g);
    chk("ill_grant", 32'(g), 32'd0);
    step(2'b00, da, db, dop, 1'b1, g);
    step(2'b00, da, db, dop, 1'b1, g);
    chk("ill_valid", 32'(rsp_valid), 32'd1);
    chk("ill_err",   32'(rsp_err),   32'd1);
    chk("ill_z",     32'(rsp_z),     32'd0);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      for (int r = 0; r < NR; r++) begin
        da[r]  = pick();
        db[r]  = pick();
        dop[r] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      end
      step(NR'($urandom), da, db, dop, ($urandom_range(0, 3) != 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 16: operand width, passed to the alu instance.
REQ-002 Parameter NUM_REQ, default 2: number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a, req_b  input  NUM_REQ x N (signed)  per-requester operands.
REQ-008 req_op  input  NUM_REQ x INSTR_WIDTH  per-requester opcode; raw bits, so illegal encodings can be presented.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the result.
REQ-012 rsp_z  output  N+1 (signed)  registered alu result.
REQ-013 rsp_flags  output  alu_flags  registered alu flags.
REQ-014 rsp_err  output  1  captured opcode not ADD/SUB/AND/OR.

Function
REQ-015 The block shall share one alu instance among NUM_REQ requesters, one operation in flight.
REQ-016 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if any req_valid, grant the first valid requester at or after rr_ptr (wrapping), drive req_ready[grant]=1 combinationally that cycle, capture a/b/op/id, go EXEC; otherwise stay IDLE.
REQ-018 req_ready shall be 0 in EXEC and RESP, and in IDLE for non-granted requesters.
REQ-019 On a grant, rr_ptr shall become grant+1, wrapping NUM_REQ-1 -> 0.
REQ-020 EXEC: alu evaluates captured operands; rsp_z, rsp_flags, rsp_err, rsp_id registered; go RESP.
REQ-021 RESP: rsp_valid=1; rsp_* stable until rsp_valid & rsp_ready, then go IDLE.
REQ-022 Latency: grant in cycle T -> rsp_valid high in cycle T+2; minimum spacing between grants 3 cycles.
REQ-023 No grant in the cycle a response handshakes; next grant is earliest the following cycle.
REQ-024 Illegal opcode: rsp_err=1, rsp_z=0 (alu default); still consumes a full EXEC/RESP slot.
REQ-025 Arithmetic: ADD/SUB result N+1 bits with carry/borrow in bit N; AND/OR bit N = 0.
REQ-026 req_valid deasserted before grant: no request recorded; requester need not hold valid.

Reset
REQ-027 rst_n low shall force, immediately: state IDLE, rr_ptr=0, rsp_valid=0, rsp_z=0, rsp_flags=0, rsp_err=0, rsp_id=0, captured operands 0.
REQ-028 Reset in EXEC or RESP shall discard the in-flight operation; no response is produced for it.
REQ-029 req_ready shall be 0 while rst_n is low.

Structure
REQ-030 alu_e, alu_flags, INSTR_WIDTH shall be reused from alu_package; the arbiter FSM state enum shall be added to alu_package.
REQ-031 Exactly one sub-module: alu, instantiated with parameter N; round-robin select implemented inline.

Verification
REQ-032 req_valid[0], ADD a=5 b=3 -> req_ready[0]=1 at T, rsp_valid at T+2, rsp_z=8, rsp_id=0, flags.Z=0, flags.N=0.
REQ-033 After reset, req_valid[0] and [1] held high -> grants 0,1,0,1 spaced 3 cycles, rsp_id matches each grant.
REQ-034 SUB a=3 b=3 from requester 1 -> rsp_z[N-1:0]=0, flags.Z=1; SUB a=2 b=5 -> rsp_z[N-1:0]=16'hFFFD, flags.N=1.
REQ-035 rsp_ready low 5 cycles in RESP with both requesters valid -> rsp_* unchanged, req_ready=0 throughout; grant follows the cycle after handshake.
REQ-036 rst_n pulsed low during EXEC -> rsp_valid=0 immediately, no response appears, next grant goes to requester 0.
REQ-037 req_op=4'b1111 -> rsp_err=1, rsp_z=0, normal T+2 timing.
